// File: rtl/punc_pkg.sv
// Shared encodings for the PUnC gen2 datapath and its controller.
// Holds the control-field encodings (alu_op, pc_sel, rf_wsel, b_sel,
// mar_sel), the memory transaction FSM state type and the CC reset value.
package punc_pkg;

    typedef enum logic [1:0] {
        PC_INC   = 2'b00,
        PC_OFF9  = 2'b01,
        PC_OFF11 = 2'b10,
        PC_ALU   = 2'b11
    } pc_sel_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_AND   = 3'b001,
        ALU_NOT   = 3'b010,
        ALU_PASSA = 3'b011,
        ALU_PASSB = 3'b100
    } alu_op_e;

    typedef enum logic [1:0] {
        WSEL_ALU = 2'b00,
        WSEL_MDR = 2'b01,
        WSEL_PC  = 2'b10
    } rf_wsel_e;

    typedef enum logic [1:0] {
        B_RD1  = 2'b00,
        B_IMM5 = 2'b01,
        B_IMM6 = 2'b10,
        B_IMM9 = 2'b11
    } b_sel_e;

    typedef enum logic {
        MAR_PC  = 1'b0,
        MAR_ALU = 1'b1
    } mar_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mem_state_e;

    localparam logic [2:0] CC_RESET = 3'b010;

    // One-hot {N,Z,P} from a value's sign bit and zero flag.
    function automatic logic [2:0] nzp(input logic msb, input logic is_zero);
        if (msb)
            return 3'b100;
        else if (is_zero)
            return 3'b010;
        else
            return 3'b001;
    endfunction

endpackage

// File: rtl/punc_regfile_param.sv
// Parametrised register file: NUM_REGS x DATA_W, two combinational read
// ports, one debug read port, one synchronous write port, async active-low
// clear of every entry.
// Ports: clk, rst (active-low), raddr0/rdata0, raddr1/rdata1,
//        waddr/wdata/we, dbg_addr/dbg_data.
// Reads see the array before the edge, so a read of the register being
// written in the same cycle returns the old value.
module punc_regfile_param #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 8,
    localparam int unsigned RA_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [RA_W-1:0]   raddr0,
    input  logic [RA_W-1:0]   raddr1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    input  logic [RA_W-1:0]   waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              we,
    input  logic [RA_W-1:0]   dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
        end else if (we) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata0   = regs[raddr0];
    assign rdata1   = regs[raddr1];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/punc_datapath_gen2.sv
// PUnC gen2 datapath: PC, IR, MAR, MDR, NZP condition codes, register file
// and ALU, with external memory reached through a valid/ready transaction
// FSM (IDLE -> REQ -> DONE) so memory can insert wait states.
// Ports: decoded control strobes from the controller (pc_*, mar_*, mem_req,
//        mem_wr, ir_ld, rf_*, a_sel, b_sel, alu_op, cc_ld); memory side
//        (mem_addr, mem_wdata, mem_valid, mem_we, mem_ready, mem_rdata);
//        status (mem_done, busy, ir, cc, branch_taken); debug read ports.
// rst is asynchronous and active-low.
module punc_datapath_gen2
    import punc_pkg::*;
#(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       NUM_REGS = 8,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    localparam int unsigned      RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_sel,
    input  logic              pc_ld,
    input  logic              mar_sel,
    input  logic              mar_ld,
    input  logic              mem_req,
    input  logic              mem_wr,
    input  logic              ir_ld,
    input  logic [RA_W-1:0]   rf_raddr0,
    input  logic [RA_W-1:0]   rf_raddr1,
    input  logic [RA_W-1:0]   rf_waddr,
    input  logic              rf_we,
    input  logic [1:0]        rf_wsel,
    input  logic              a_sel,
    input  logic [1:0]        b_sel,
    input  logic [2:0]        alu_op,
    input  logic              cc_ld,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_valid,
    output logic              mem_we,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              busy,
    output logic [DATA_W-1:0] ir,
    output logic [2:0]        cc,
    output logic              branch_taken,
    input  logic [RA_W-1:0]   rf_debug_addr,
    output logic [DATA_W-1:0] rf_debug_data,
    output logic [DATA_W-1:0] pc_debug_data
);

    logic [DATA_W-1:0] pc, mar, mdr, wbuf;
    logic [DATA_W-1:0] rd0, rd1;
    logic [DATA_W-1:0] alu_a, alu_b, alu_result;
    logic [DATA_W-1:0] rf_wdata, pc_next;
    logic [DATA_W-1:0] imm5, imm6, off9, off11;
    mem_state_e        state;

    punc_regfile_param #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .raddr0   (rf_raddr0),
        .raddr1   (rf_raddr1),
        .rdata0   (rd0),
        .rdata1   (rd1),
        .waddr    (rf_waddr),
        .wdata    (rf_wdata),
        .we       (rf_we),
        .dbg_addr (rf_debug_addr),
        .dbg_data (rf_debug_data)
    );

    assign imm5  = {{(DATA_W-5){ir[4]}},   ir[4:0]};
    assign imm6  = {{(DATA_W-6){ir[5]}},   ir[5:0]};
    assign off9  = {{(DATA_W-9){ir[8]}},   ir[8:0]};
    assign off11 = {{(DATA_W-11){ir[10]}}, ir[10:0]};

    always_comb begin
        alu_a = a_sel ? pc : rd0;
        case (b_sel)
            B_RD1:   alu_b = rd1;
            B_IMM5:  alu_b = imm5;
            B_IMM6:  alu_b = imm6;
            default: alu_b = off9;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALU_ADD:   alu_result = alu_a + alu_b;
            ALU_AND:   alu_result = alu_a & alu_b;
            ALU_NOT:   alu_result = ~alu_a;
            ALU_PASSB: alu_result = alu_b;
            default:   alu_result = alu_a;
        endcase
    end

    always_comb begin
        case (pc_sel)
            PC_INC:   pc_next = pc + 1'b1;
            PC_OFF9:  pc_next = pc + off9;
            PC_OFF11: pc_next = pc + off11;
            default:  pc_next = alu_result;
        endcase
    end

    always_comb begin
        case (rf_wsel)
            WSEL_MDR: rf_wdata = mdr;
            WSEL_PC:  rf_wdata = pc;
            default:  rf_wdata = alu_result;
        endcase
    end

    // Architectural registers; MAR is frozen while a transaction is in REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc  <= RESET_PC;
            ir  <= '0;
            mar <= '0;
            cc  <= CC_RESET;
        end else begin
            if (pc_ld)
                pc <= pc_next;
            if (ir_ld)
                ir <= mdr;
            if (mar_ld && !busy)
                mar <= (mar_sel == MAR_ALU) ? alu_result : pc;
            if (cc_ld)
                cc <= nzp(rf_wdata[DATA_W-1], rf_wdata == '0);
        end
    end

    // Memory transaction FSM with registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            mem_valid <= 1'b0;
            mem_we    <= 1'b0;
            mem_done  <= 1'b0;
            busy      <= 1'b0;
            wbuf      <= '0;
            mdr       <= '0;
        end else begin
            mem_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        state     <= ST_REQ;
                        mem_valid <= 1'b1;
                        mem_we    <= mem_wr;
                        busy      <= 1'b1;
                        wbuf      <= rd1;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        if (!mem_we)
                            mdr <= mem_rdata;
                        state     <= ST_DONE;
                        mem_valid <= 1'b0;
                        mem_we    <= 1'b0;
                        busy      <= 1'b0;
                        mem_done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_addr      = mar;
    assign mem_wdata     = wbuf;
    assign branch_taken  = |(ir[11:9] & cc);
    assign pc_debug_data = pc;

endmodule

// File: tb/tb_punc_datapath_gen2.sv
module tb_punc_datapath_gen2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: DATA_W=16, NUM_REGS=8
    logic [1:0]  pc_sel, rf_wsel, b_sel;
    logic        pc_ld, mar_sel, mar_ld, mem_req, mem_wr, ir_ld, rf_we, a_sel, cc_ld;
    logic [2:0]  rf_raddr0, rf_raddr1, rf_waddr, rf_debug_addr, alu_op;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, ir, rf_debug_data, pc_debug_data;
    logic        mem_valid, mem_we, mem_ready, mem_done, busy, branch_taken;
    logic [2:0]  cc;

    // Instance B: DATA_W=32, NUM_REGS=16, RESET_PC=0x100
    logic [1:0]  b_pc_sel, b_rf_wsel;
    logic        b_pc_ld, b_rf_we, b_cc_ld;
    logic [2:0]  b_alu_op;
    logic [3:0]  b_raddr0, b_waddr, b_dbg_addr;
    logic [31:0] b_mem_addr, b_mem_wdata, b_ir, b_dbg_data, b_pc;
    logic        b_mem_valid, b_mem_we, b_mem_done, b_busy, b_bt;
    logic [2:0]  b_cc;

    punc_datapath_gen2 #(.DATA_W(16), .NUM_REGS(8), .RESET_PC(16'h0000)) dut_a (
        .clk(clk), .rst(rst), .pc_sel(pc_sel), .pc_ld(pc_ld), .mar_sel(mar_sel),
        .mar_ld(mar_ld), .mem_req(mem_req), .mem_wr(mem_wr), .ir_ld(ir_ld),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_waddr(rf_waddr),
        .rf_we(rf_we), .rf_wsel(rf_wsel), .a_sel(a_sel), .b_sel(b_sel),
        .alu_op(alu_op), .cc_ld(cc_ld), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .busy(busy), .ir(ir), .cc(cc),
        .branch_taken(branch_taken), .rf_debug_addr(rf_debug_addr),
        .rf_debug_data(rf_debug_data), .pc_debug_data(pc_debug_data)
    );

    punc_datapath_gen2 #(.DATA_W(32), .NUM_REGS(16), .RESET_PC(32'h0000_0100)) dut_b (
        .clk(clk), .rst(rst), .pc_sel(b_pc_sel), .pc_ld(b_pc_ld), .mar_sel(1'b0),
        .mar_ld(1'b0), .mem_req(1'b0), .mem_wr(1'b0), .ir_ld(1'b0),
        .rf_raddr0(b_raddr0), .rf_raddr1(4'd0), .rf_waddr(b_waddr),
        .rf_we(b_rf_we), .rf_wsel(b_rf_wsel), .a_sel(1'b0), .b_sel(2'b00),
        .alu_op(b_alu_op), .cc_ld(b_cc_ld), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_valid(b_mem_valid), .mem_we(b_mem_we), .mem_ready(1'b0),
        .mem_rdata(32'd0), .mem_done(b_mem_done), .busy(b_busy), .ir(b_ir), .cc(b_cc),
        .branch_taken(b_bt), .rf_debug_addr(b_dbg_addr),
        .rf_debug_data(b_dbg_data), .pc_debug_data(b_pc)
    );

    int total = 0;
    int bad   = 0;

    // Reference state for the random phase
    logic [15:0] m [8];
    logic [2:0]  mcc;

    function automatic logic [15:0] ref_alu(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a & b;
            3'd2:    return ~a;
            3'd4:    return b;
            default: return a;
        endcase
    endfunction

    function automatic logic [2:0] ref_cc(input logic [15:0] v);
        if (v[15])          return 3'b100;
        else if (v == 16'd0) return 3'b010;
        else                return 3'b001;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        pc_ld = 0; mar_ld = 0; mem_req = 0; ir_ld = 0; rf_we = 0; cc_ld = 0;
    endtask

    // Read with mem_ready high; returns in the DONE cycle (MDR updated).
    task automatic mem_read(input logic [15:0] val);
        mem_rdata = val; mem_ready = 1; mem_wr = 0; mem_req = 1;
        step;
        mem_req = 0;
        for (int n = 0; n < 20 && !mem_done; n++) step;
        chk("rd_done", {63'd0, mem_done}, 64'd1);
    endtask

    task automatic load_reg(input logic [2:0] r, input logic [15:0] val);
        mem_read(val);
        rf_we = 1; rf_wsel = 2'b01; rf_waddr = r;
        step;
        rf_we = 0;
        m[r] = val;
    endtask

    task automatic load_ir(input logic [15:0] val);
        mem_read(val);
        ir_ld = 1;
        step;
        ir_ld = 0;
    endtask

    task automatic dbg_chk(input string tag, input logic [2:0] r, input logic [15:0] exp);
        rf_debug_addr = r;
        #1;
        chk(tag, {48'd0, rf_debug_data}, {48'd0, exp});
    endtask

    initial begin
        logic [2:0]  op, ra, rb, rd;
        logic        we;
        logic [15:0] exp;

        rst = 0;
        pc_sel = 0; rf_wsel = 0; b_sel = 0; a_sel = 0; mar_sel = 0; mem_wr = 0;
        rf_raddr0 = 0; rf_raddr1 = 0; rf_waddr = 0; rf_debug_addr = 0; alu_op = 0;
        mem_rdata = 0; mem_ready = 0;
        idle;
        b_pc_sel = 0; b_rf_wsel = 0; b_pc_ld = 0; b_rf_we = 0; b_cc_ld = 0;
        b_alu_op = 0; b_raddr0 = 0; b_waddr = 0; b_dbg_addr = 0;
        for (int i = 0; i < 8; i++) m[i] = 16'd0;

        // Reset state
        step; step;
        chk("rst_pc", {48'd0, pc_debug_data}, 64'd0);
        chk("rst_cc", {61'd0, cc}, 64'd2);
        chk("rst_ir", {48'd0, ir}, 64'd0);
        chk("rst_valid", {62'd0, mem_valid, busy}, 64'd0);
        rst = 1;
        step;

        // 1: minimum-latency read, then IR load
        mem_ready = 1; mem_rdata = 16'h1234; mar_sel = 0; mar_ld = 1; mem_req = 1;
        step;
        idle;
        chk("t1_valid_c1", {62'd0, mem_valid, busy}, 64'd3);
        chk("t1_done_c1", {63'd0, mem_done}, 64'd0);
        chk("t1_addr", {48'd0, mem_addr}, 64'd0);
        chk("t1_we", {63'd0, mem_we}, 64'd0);
        step;
        chk("t1_done_c2", {63'd0, mem_done}, 64'd1);
        chk("t1_valid_c2", {62'd0, mem_valid, busy}, 64'd0);
        ir_ld = 1;
        step;
        ir_ld = 0;
        chk("t1_ir", {48'd0, ir}, 64'h1234);
        chk("t1_done_c3", {63'd0, mem_done}, 64'd0);
        // ir_ld in the cycle MDR is written takes the old MDR
        mem_rdata = 16'hABCD; mem_req = 1;
        step;
        mem_req = 0; ir_ld = 1;
        step;
        ir_ld = 0;
        chk("t1_ir_old_mdr", {48'd0, ir}, 64'h1234);
        ir_ld = 1;
        step;
        ir_ld = 0;
        chk("t1_ir_new_mdr", {48'd0, ir}, 64'hABCD);

        // 2: ADD overflow to negative, AND with imm5 zero
        load_reg(3'd1, 16'h7FFF);
        load_reg(3'd2, 16'h0001);
        rf_raddr0 = 1; rf_raddr1 = 2; a_sel = 0; b_sel = 2'b00; alu_op = 3'b000;
        rf_wsel = 2'b00; rf_waddr = 3; rf_we = 1; cc_ld = 1;
        step;
        idle;
        dbg_chk("t2_add", 3'd3, 16'h8000);
        chk("t2_cc_n", {61'd0, cc}, 64'd4);
        load_ir(16'h5020);
        rf_raddr0 = 3; b_sel = 2'b01; alu_op = 3'b001; rf_wsel = 2'b00;
        rf_waddr = 3; rf_we = 1; cc_ld = 1;
        step;
        idle;
        dbg_chk("t2_and", 3'd3, 16'h0000);
        chk("t2_cc_z", {61'd0, cc}, 64'd2);
        m[3] = 16'h0000;

        // 3: PC-relative targets and branch condition
        load_reg(3'd4, 16'h0010);
        rf_raddr1 = 4; a_sel = 0; b_sel = 2'b00; alu_op = 3'b100; pc_sel = 2'b11; pc_ld = 1;
        step;
        idle;
        chk("t3_pc_alu", {48'd0, pc_debug_data}, 64'h10);
        load_ir(16'h0FFE);
        chk("t3_bt_z", {63'd0, branch_taken}, 64'd1);
        // cc_ld without rf_we: P from R1, N from NOT R4
        rf_raddr0 = 1; alu_op = 3'b011; rf_wsel = 2'b00; cc_ld = 1;
        step;
        idle;
        chk("t3_cc_p", {61'd0, cc}, 64'd1);
        chk("t3_bt_p", {63'd0, branch_taken}, 64'd1);
        rf_raddr0 = 4; alu_op = 3'b010; cc_ld = 1;
        step;
        idle;
        chk("t3_cc_n", {61'd0, cc}, 64'd4);
        chk("t3_bt_n", {63'd0, branch_taken}, 64'd1);
        dbg_chk("t3_r4_kept", 3'd4, 16'h0010);
        pc_sel = 2'b01; pc_ld = 1;
        step;
        chk("t3_pc_off9", {48'd0, pc_debug_data}, 64'h0E);
        pc_sel = 2'b10;
        step;
        chk("t3_pc_off11", {48'd0, pc_debug_data}, 64'h0C);
        pc_sel = 2'b00;
        step;
        idle;
        chk("t3_pc_inc", {48'd0, pc_debug_data}, 64'h0D);
        load_ir(16'h01FE);
        chk("t3_bt_none", {63'd0, branch_taken}, 64'd0);

        // Random ALU operations against the reference model
        for (int i = 0; i < 8; i++) load_reg(i[2:0], 16'($urandom));
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            rd = 3'($urandom_range(0, 7));
            we = 1'($urandom_range(0, 1));
            rf_raddr0 = ra; rf_raddr1 = rb; a_sel = 0; b_sel = 2'b00; alu_op = op;
            rf_wsel = 2'b00; rf_waddr = rd; rf_we = we; cc_ld = 1; rf_debug_addr = rd;
            #1;
            chk("rnd_old", {48'd0, rf_debug_data}, {48'd0, m[rd]});
            exp = ref_alu(op, m[ra], m[rb]);
            step;
            idle;
            if (we) m[rd] = exp;
            mcc = ref_cc(exp);
            chk("rnd_reg", {48'd0, rf_debug_data}, {48'd0, m[rd]});
            chk("rnd_cc", {61'd0, cc}, {61'd0, mcc});
        end

        // 4: write transaction with wait states
        load_reg(3'd5, 16'hBEEF);
        load_reg(3'd6, 16'h0040);
        rf_raddr0 = 6; a_sel = 0; alu_op = 3'b011; mar_sel = 1; mar_ld = 1;
        step;
        idle;
        mem_ready = 0; mem_rdata = 16'hDEAD; rf_raddr1 = 5; mem_wr = 1; mem_req = 1;
        step;
        mem_req = 0; mem_wr = 0; rf_raddr1 = 0; rf_raddr0 = 5; mar_ld = 1;
        for (int k = 0; k < 3; k++) begin
            chk("t4_valid", {62'd0, mem_valid, mem_we}, 64'd3);
            chk("t4_addr", {48'd0, mem_addr}, 64'h0040);
            chk("t4_wdata", {48'd0, mem_wdata}, 64'hBEEF);
            chk("t4_done", {62'd0, mem_done, busy}, 64'd1);
            step;
        end
        mar_ld = 0; mem_ready = 1;
        chk("t4_valid_c4", {62'd0, mem_valid, mem_we}, 64'd3);
        step;
        chk("t4_done_pulse", {63'd0, mem_done}, 64'd1);
        chk("t4_released", {61'd0, mem_valid, mem_we, busy}, 64'd0);
        step;
        chk("t4_done_end", {63'd0, mem_done}, 64'd0);
        chk("t4_mar_frozen", {48'd0, mem_addr}, 64'h0040);
        ir_ld = 1;
        step;
        ir_ld = 0;
        chk("t4_mdr_kept", {48'd0, ir}, 64'h0040);

        // 5: async reset during REQ, then mem_req during DONE ignored
        mem_ready = 0; mem_wr = 0; mem_req = 1;
        step;
        mem_req = 0;
        chk("t5_req", {63'd0, mem_valid}, 64'd1);
        #2 rst = 0;
        #1;
        chk("t5_rst_valid", {60'd0, mem_valid, mem_we, mem_done, busy}, 64'd0);
        chk("t5_rst_cc", {61'd0, cc}, 64'd2);
        chk("t5_rst_pc", {48'd0, pc_debug_data}, 64'd0);
        dbg_chk("t5_rst_r5", 3'd5, 16'h0000);
        rst = 1;
        step;
        mem_ready = 1; mem_req = 1;
        step;
        mem_req = 0;
        step;
        chk("t5_done", {63'd0, mem_done}, 64'd1);
        mem_req = 1;
        step;
        mem_req = 0;
        chk("t5_ignored", {62'd0, mem_valid, busy}, 64'd0);
        step;
        chk("t5_ignored2", {62'd0, mem_valid, busy}, 64'd0);

        // 6: wide instance
        chk("t6_reset_pc", {32'd0, b_pc}, 64'h100);
        b_pc_sel = 2'b00; b_pc_ld = 1;
        step; step;
        b_pc_ld = 0;
        chk("t6_pc_inc", {32'd0, b_pc}, 64'h102);
        b_rf_wsel = 2'b10; b_waddr = 15; b_rf_we = 1; b_cc_ld = 1;
        step;
        b_rf_we = 0; b_cc_ld = 0; b_dbg_addr = 15;
        #1;
        chk("t6_r15", {32'd0, b_dbg_data}, 64'h102);
        chk("t6_cc", {61'd0, b_cc}, 64'd1);
        b_raddr0 = 0; b_alu_op = 3'b010; b_pc_sel = 2'b11; b_pc_ld = 1;
        step;
        chk("t6_pc_max", {32'd0, b_pc}, 64'hFFFF_FFFF);
        b_pc_sel = 2'b00;
        step;
        b_pc_ld = 0;
        chk("t6_pc_wrap", {32'd0, b_pc}, 64'd0);
        chk("t6_r15_kept", {32'd0, b_dbg_data}, 64'h102);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/punc_datapath_gen2.md
Name: punc_datapath_gen2

Overview:
- Parametrised second-generation PUnC datapath for the LC3-style multicycle processor.
- Contains PC, IR, MAR, MDR, condition codes, an internal NUM_REGS x DATA_W register file and an ALU.
- Memory sits outside the block behind a valid/ready handshake with a transaction FSM, so memory may insert wait states.
- The existing controller drives it through decoded control strobes.

Parameters:
- DATA_W, 16, datapath/address width; must be >= 16 (IR fields sit at LC3 bit positions).
- NUM_REGS, 8, register count; power of two, >= 2; RA_W = log2(NUM_REGS).
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- pc_sel  in  2  PC source: 00 pc+1, 01 pc+sext(ir[8:0]), 10 pc+sext(ir[10:0]), 11 alu_result
- pc_ld  in  1  load PC
- mar_sel  in  1  0: PC, 1: alu_result
- mar_ld  in  1  load MAR
- mem_req  in  1  start memory transaction
- mem_wr  in  1  transaction is a write (sampled with mem_req)
- ir_ld  in  1  IR <= MDR
- rf_raddr0, rf_raddr1  in  RA_W  read addresses
- rf_waddr  in  RA_W  write address
- rf_we  in  1  register write enable
- rf_wsel  in  2  write data: 00 alu_result, 01 MDR, 10 PC
- a_sel  in  1  ALU A: 0 rd0, 1 PC
- b_sel  in  2  ALU B: 00 rd1, 01 sext(ir[4:0]), 10 sext(ir[5:0]), 11 sext(ir[8:0])
- alu_op  in  3  000 ADD, 001 AND, 010 NOT A, 011 PASS A, 100 PASS B, others PASS A
- cc_ld  in  1  update NZP from register write data
- mem_addr  out  DATA_W  to memory
- mem_wdata  out  DATA_W  to memory
- mem_valid  out  1  request valid
- mem_we  out  1  write qualifier
- mem_ready  in  1  memory accepts/completes
- mem_rdata  in  DATA_W  read data, valid with mem_ready
- mem_done  out  1  one-cycle pulse on completion
- busy  out  1  transaction outstanding
- ir  out  DATA_W  instruction register
- cc  out  3  {N,Z,P}
- branch_taken  out  1  |(ir[11:9] & cc)
- rf_debug_addr  in  RA_W  debug read address
- rf_debug_data  out  DATA_W  debug read data
- pc_debug_data  out  DATA_W  current PC

Behaviour:
- Reset (async, rst=0): PC = RESET_PC; IR, MAR, MDR and all registers = 0; cc = 3'b010; FSM = IDLE; mem_valid, mem_we, mem_done, busy = 0 immediately (mid-transaction too).
- Register file: two combinational read ports plus debug port; write at posedge.
  - A debug or read port addressing a register being written in the same cycle returns the old value.
- Sign extension: each field is sign-extended from its top bit to DATA_W.
- ADD wraps modulo 2^DATA_W with no carry out. NOT is bitwise.
- PC update:
  - Relative targets use the current PC, which the controller has already incremented.
  - pc_ld with pc_sel=00 gives pc+1, wrapping at 2^DATA_W-1 to 0.
- CC update:
  - On cc_ld, cc is computed from the value selected by rf_wsel: N = msb, Z = all-zero, P otherwise. Always one-hot.
  - cc_ld is legal without rf_we.
- Memory FSM (mem_addr = MAR; mem_wdata = rd1, latched into a write buffer at the request):
  - IDLE: on mem_req, latch mem_wr and rd1, go to REQ. busy=1 from the next cycle.
  - REQ: mem_valid=1, mem_we=latched mem_wr. mem_addr/mem_wdata stay stable until mem_ready. On mem_ready: for a read, MDR <= mem_rdata; go to DONE.
  - DONE: mem_done=1 for exactly one cycle, busy=0, return to IDLE.
  - Minimum latency with mem_ready tied high: request at cycle 0, mem_done at cycle 2, MDR usable at cycle 2.
  - mem_req while REQ/DONE: ignored, no queueing.
  - mar_ld while busy: ignored (MAR frozen).
  - ir_ld in the same cycle MDR is written: IR takes the old MDR.
- Other strobes (pc_ld, rf_we, ir_ld, cc_ld) act independently and may coincide in any cycle.

Decomposition:
- Shared package punc_pkg:
  - alu_op, pc_sel, rf_wsel, b_sel, mar_sel encodings
  - FSM state typedef (IDLE/REQ/DONE)
  - CC reset constant
- One natural sub-module: punc_regfile_param (NUM_REGS x DATA_W, 2 read, 1 write, 1 debug, async active-low clear), reusable by the controller bench.

Test Plan:
1. Reset then release; mem_ready high; mar_sel=0, mar_ld, mem_req (read), mem_rdata=16'h1234 -> mem_valid cycle 1, mem_done cycle 2, MDR=16'h1234; ir_ld -> ir=16'h1234.
2. R1=16'h7FFF, R2=1, ADD into R3 with cc_ld -> R3=16'h8000, cc=3'b100. Then AND R3 with imm5 0 -> R3=0, cc=3'b010.
3. PC=16'h0010, IR=16'h0FFE (BRnzp, off9=-2), pc_sel=01 with pc_ld -> PC=16'h000E; branch_taken=1 for any cc.
4. Write R5=16'hBEEF, MAR=16'h0040, mem_req with mem_wr=1, mem_ready held low 3 cycles -> mem_valid/mem_we/addr/wdata stable 3 cycles, mem_done one cycle after ready.
5. Assert rst low during REQ -> mem_valid drops without a clock edge, cc=3'b010, PC=RESET_PC; a mem_req during DONE is ignored.
6. DATA_W=32, NUM_REGS=16: R15 <= PC via rf_wsel=10; debug read of R15 returns the PC; pc+1 from 32'hFFFFFFFF wraps to 0.
